fb_swap_arbiter: RTL and testbench

FB_SWAP_ARBITER -- requirements
Module: fb_swap_arbiter

---
 rtl/fb_swap_arbiter.sv | 130 +++++++++++++
 tb/tb_fb_swap_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fb_swap_arbiter.sv
// Double-buffered framebuffer write arbiter: round-robin between two writers, vsync-aligned swap, optional clear.
// Grants are combinational; write port and status strobes are registered one cycle after the grant.
module fb_swap_arbiter #(
  parameter int                ADDR_W        = 19,
  parameter int                DATA_W        = 4,
  parameter int                FB_DEPTH      = 307200,
  parameter int                CLEAR_ON_SWAP = 1,
  parameter logic [DATA_W-1:0] CLEAR_COLOR   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              frame_done,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_buf,
  output logic              front_sel,
  output logic              swap_pulse,
  output logic              oob_pulse,
  output logic              overrun_pulse,
  output logic              busy
);

  typedef enum logic [1:0] {RUN, WAIT_SWAP, CLEAR} state_t;

  // One extra bit so FB_DEPTH itself is representable for the range compare.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(FB_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  state_t            state, state_next;
  logic              vsync_q;
  logic              vsync_rise;
  logic              rr_ptr;
  logic [ADDR_W-1:0] clr_cnt;
  logic              grant;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              in_range;
  logic              swap;
  logic              overrun;
  logic              clr_wr;

  assign vsync_rise = vsync && !vsync_q;
  assign busy       = (state != RUN);
  assign grant      = req0_ready || req1_ready;
  assign acc_addr   = req1_ready ? req1_addr : req0_addr;
  assign acc_data   = req1_ready ? req1_data : req0_data;
  assign in_range   = ({1'b0, acc_addr} < DEPTH_EXT);

  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    swap       = 1'b0;
    overrun    = 1'b0;
    clr_wr     = 1'b0;
    case (state)
      RUN: begin
        if (req0_valid && (!req1_valid || !rr_ptr)) req0_ready = 1'b1;
        else if (req1_valid)                        req1_ready = 1'b1;
        // A vsync edge coinciding with frame_done is consumed here, so the swap waits for the next one.
        if (frame_done) state_next = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        overrun = frame_done;
        if (vsync_rise) begin
          swap       = 1'b1;
          state_next = (CLEAR_ON_SWAP != 0) ? CLEAR : RUN;
        end
      end
      CLEAR: begin
        overrun = frame_done;
        clr_wr  = 1'b1;
        if (clr_cnt == LAST_ADDR) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      vsync_q       <= 1'b1;
      rr_ptr        <= 1'b0;
      clr_cnt       <= '0;
      front_sel     <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      wr_buf        <= 1'b1;
      swap_pulse    <= 1'b0;
      oob_pulse     <= 1'b0;
      overrun_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      vsync_q       <= vsync;
      swap_pulse    <= swap;
      overrun_pulse <= overrun;
      oob_pulse     <= grant && !in_range;
      wr_buf        <= ~front_sel;
      if (grant) rr_ptr <= req0_ready;
      if (clr_wr) begin
        wr_en   <= 1'b1;
        wr_addr <= clr_cnt;
        wr_data <= CLEAR_COLOR;
        clr_cnt <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + ADDR_W'(1);
      end else if (grant && in_range) begin
        wr_en   <= 1'b1;
        wr_addr <= acc_addr;
        wr_data <= acc_data;
      end else begin
        wr_en   <= 1'b0;
      end
      if (swap) begin
        front_sel <= ~front_sel;
        clr_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fb_swap_arbiter.sv
// Directed bench for fb_swap_arbiter with a 16-pixel framebuffer.
module tb_fb_swap_arbiter;

  localparam int AW = 5;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vsync, frame_done;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          wr_en, wr_buf, front_sel, swap_pulse, oob_pulse, overrun_pulse, busy;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int checks = 0;
  int errors = 0;

  fb_swap_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(16), .CLEAR_ON_SWAP(1), .CLEAR_COLOR(4'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .frame_done(frame_done),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_buf(wr_buf),
    .front_sel(front_sel), .swap_pulse(swap_pulse), .oob_pulse(oob_pulse),
    .overrun_pulse(overrun_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_front_sel"}, front_sel, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_wr_buf"}, wr_buf, 1);
    chk({tag, "_swap"}, swap_pulse, 0);
    chk({tag, "_oob"}, oob_pulse, 0);
    chk({tag, "_overrun"}, overrun_pulse, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; vsync = 1'b0; frame_done = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    cyc(); cyc();
    chk_reset_outputs("rst");
    chk("rst_ready0", req0_ready, 0);
    rst_n = 1'b1;

    // Two contending writers alternate, starting with req0
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 4'hA;
    req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 4'h5;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready0", req0_ready, (i % 2 == 0));
      chk("rr_ready1", req1_ready, (i % 2 == 1));
      cyc();
      chk("rr_wr_en", wr_en, 1);
      chk("rr_wr_addr", wr_addr, (i % 2 == 0) ? 3 : 5);
      chk("rr_wr_data", wr_data, (i % 2 == 0) ? 4'hA : 4'h5);
      chk("rr_wr_buf", wr_buf, 1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("idle_ready0", req0_ready, 0);
    chk("idle_ready1", req1_ready, 0);
    req1_valid = 1'b1;
    #1;
    chk("solo_ready1", req1_ready, 1);
    chk("solo_ready0", req0_ready, 0);
    cyc();
    chk("solo_wr_en", wr_en, 1);
    chk("solo_wr_addr", wr_addr, 5);
    req1_valid = 1'b0;

    // Out-of-range address is consumed without a write
    req0_valid = 1'b1; req0_addr = 5'd16; req0_data = 4'h7;
    #1;
    chk("oob_ready0", req0_ready, 1);
    cyc();
    chk("oob_wr_en", wr_en, 0);
    chk("oob_pulse", oob_pulse, 1);
    req0_valid = 1'b0;
    cyc();
    chk("oob_pulse_end", oob_pulse, 0);

    // frame_done, vsync 10 cycles later, then a 16-pixel clear into buffer 0
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    chk("wait_busy", busy, 1);
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 4'hA;
    for (int k = 0; k < 9; k++) begin
      cyc();
      chk("wait_ready0", req0_ready, 0);
      chk("wait_wr_en", wr_en, 0);
      chk("wait_front", front_sel, 0);
    end
    vsync = 1'b1;
    cyc();
    chk("swap_pulse", swap_pulse, 1);
    chk("swap_front", front_sel, 1);
    chk("clear_busy", busy, 1);
    chk("clear_ready0", req0_ready, 0);
    for (int j = 0; j < 16; j++) begin
      cyc();
      chk("clr_wr_en", wr_en, 1);
      chk("clr_wr_addr", wr_addr, j);
      chk("clr_wr_data", wr_data, 0);
      chk("clr_wr_buf", wr_buf, 0);
      if (j == 2) vsync = 1'b0;
      if (j == 4) vsync = 1'b1;
    end
    chk("clr_done_front", front_sel, 1);
    chk("clr_done_busy", busy, 0);
    chk("clr_done_swap", swap_pulse, 0);
    chk("run_ready0", req0_ready, 1);
    cyc();
    chk("run_wr_addr", wr_addr, 3);
    chk("run_wr_buf", wr_buf, 0);
    req0_valid = 1'b0;

    // frame_done on the same cycle as a vsync edge waits for the next edge
    vsync = 1'b0;
    cyc();
    frame_done = 1'b1; vsync = 1'b1;
    cyc();
    frame_done = 1'b0;
    chk("coinc_swap", swap_pulse, 0);
    chk("coinc_busy", busy, 1);
    chk("coinc_front", front_sel, 1);
    vsync = 1'b0;
    cyc(); cyc();
    chk("coinc_still_front", front_sel, 1);
    vsync = 1'b1;
    cyc();
    chk("next_swap", swap_pulse, 1);
    chk("next_front", front_sel, 0);

    // Overrun during clear, then reset in the middle of the clear
    cyc();
    chk("clr2_addr0", wr_addr, 0);
    chk("clr2_wr_buf", wr_buf, 1);
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    chk("overrun_pulse", overrun_pulse, 1);
    chk("clr2_addr1", wr_addr, 1);
    cyc();
    chk("overrun_end", overrun_pulse, 0);
    chk("no_extra_swap", swap_pulse, 0);
    chk("clr2_addr2", wr_addr, 2);
    for (int a = 3; a < 8; a++) begin
      cyc();
      chk("clr2_addr", wr_addr, a);
    end
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midclr");
    cyc(); cyc();
    chk("midclr_hold_wr_en", wr_en, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_busy", busy, 0);
    cyc();
    chk("post_rst_wr_en", wr_en, 0);
    chk("post_rst_swap", swap_pulse, 0);
    chk("post_rst_busy2", busy, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("post_rst_ready0", req0_ready, 1);
    chk("post_rst_ready1", req1_ready, 0);
    cyc();
    chk("post_rst_wr_addr", wr_addr, 3);
    chk("post_rst_wr_buf", wr_buf, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
